// File: rtl/alarm_seq.sv
// alarm_seq: alarm-clock sequencer (IDLE -> RING -> SNOOZE/HOLD -> IDLE).
// Counts whole seconds from i_sec_tick to time the ring and snooze windows.
// Build option: define ALARM_SNOOZE_EN to enable the snooze path. Without it,
// the snooze button behaves as a stop button and o_snooze_cnt stays 0.
module alarm_seq #(
  parameter int P_RING_SEC   = 60,
  parameter int P_SNOOZE_SEC = 300,
  parameter int P_MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_alarm_en,
  input  logic       i_match,
  input  logic       i_sec_tick,
  input  logic       i_sw_stop,
  input  logic       i_sw_snooze,
  output logic       o_buzz_en,
  output logic [1:0] o_state,
  output logic [1:0] o_snooze_cnt,
  output logic       o_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2,
    HOLD   = 2'd3
  } state_t;

`ifdef ALARM_SNOOZE_EN
  localparam logic SNOOZE_EN = 1'b1;
`else
  localparam logic SNOOZE_EN = 1'b0;
`endif

  // Last second index of each timed window; the tick that arrives while the
  // counter sits on this value ends the window.
  localparam logic [8:0] RING_LAST   = 9'(P_RING_SEC - 1);
  localparam logic [8:0] SNOOZE_LAST = 9'(P_SNOOZE_SEC - 1);
  localparam logic [1:0] MAX_SNOOZE  = 2'(P_MAX_SNOOZE);

  state_t     state;
  logic [8:0] sec_cnt;

  // The state register is itself the encoded state output.
  assign o_state = state;

  // Single sequencer: state, second counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sec_cnt      <= '0;
      o_buzz_en    <= 1'b0;
      o_snooze_cnt <= 2'd0;
      o_done       <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (!i_alarm_en) begin
        // Disarming silently abandons the event from any state.
        state        <= IDLE;
        sec_cnt      <= '0;
        o_buzz_en    <= 1'b0;
        o_snooze_cnt <= 2'd0;
      end else begin
        case (state)
          IDLE: begin
            if (i_match) begin
              state     <= RING;
              sec_cnt   <= '0;
              o_buzz_en <= 1'b1;
            end
          end

          RING: begin
            if (i_sw_stop || i_sw_snooze) begin
              sec_cnt   <= '0;
              o_buzz_en <= 1'b0;
              // Stop wins over snooze; an exhausted or disabled snooze
              // dismisses the alarm instead.
              if (!i_sw_stop && SNOOZE_EN && (o_snooze_cnt < MAX_SNOOZE)) begin
                state        <= SNOOZE;
                o_snooze_cnt <= o_snooze_cnt + 2'd1;
              end else begin
                state  <= HOLD;
                o_done <= 1'b1;
              end
            end else if (i_sec_tick) begin
              if (sec_cnt == RING_LAST) begin
                state     <= HOLD;
                sec_cnt   <= '0;
                o_buzz_en <= 1'b0;
                o_done    <= 1'b1;
              end else begin
                sec_cnt <= sec_cnt + 9'd1;
              end
            end
          end

          SNOOZE: begin
            // The snooze button is deliberately ignored while snoozing.
            if (i_sw_stop) begin
              state   <= HOLD;
              sec_cnt <= '0;
              o_done  <= 1'b1;
            end else if (i_sec_tick) begin
              if (sec_cnt == SNOOZE_LAST) begin
                state     <= RING;
                sec_cnt   <= '0;
                o_buzz_en <= 1'b1;
              end else begin
                sec_cnt <= sec_cnt + 9'd1;
              end
            end
          end

          HOLD: begin
            // Wait out the matching second so the alarm cannot re-trigger.
            if (!i_match) begin
              state        <= IDLE;
              sec_cnt      <= '0;
              o_snooze_cnt <= 2'd0;
            end
          end

          default: begin
            state     <= IDLE;
            sec_cnt   <= '0;
            o_buzz_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alarm_seq.sv
// tb_alarm_seq: table-driven directed checks for alarm_seq plus hand-written
// multi-cycle sequences (ring timeout, async reset, snooze handling).
module tb_alarm_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_alarm_en = 1'b0;
  logic       i_match = 1'b0;
  logic       i_sec_tick = 1'b0;
  logic       i_sw_stop = 1'b0;
  logic       i_sw_snooze = 1'b0;
  logic       o_buzz_en;
  logic [1:0] o_state;
  logic [1:0] o_snooze_cnt;
  logic       o_done;

  int checks = 0;
  int errors = 0;

  alarm_seq dut (
    .clk          (clk),
    .rst          (rst),
    .i_alarm_en   (i_alarm_en),
    .i_match      (i_match),
    .i_sec_tick   (i_sec_tick),
    .i_sw_stop    (i_sw_stop),
    .i_sw_snooze  (i_sw_snooze),
    .o_buzz_en    (o_buzz_en),
    .o_state      (o_state),
    .o_snooze_cnt (o_snooze_cnt),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  // Inputs {en, match, tick, stop, snooze} and expected {state, buzz, cnt, done}.
  typedef struct packed {
    logic       en;
    logic       match;
    logic       tick;
    logic       stop;
    logic       snz;
    logic [1:0] st;
    logic       buzz;
    logic [1:0] cnt;
    logic       done;
  } vec_t;

  vec_t tbl [16];

  function automatic logic [5:0] outs();
    return {o_state, o_buzz_en, o_snooze_cnt, o_done};
  endfunction

  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = outs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got state=%0d buzz=%b cnt=%0d done=%b, expected state=%0d buzz=%b cnt=%0d done=%b",
               name, act[5:4], act[3], act[2:1], act[0], exp[5:4], exp[3], exp[2:1], exp[0]);
    end else begin
      $display("ok   %s: state=%0d buzz=%b cnt=%0d done=%b", name, act[5:4], act[3], act[2:1], act[0]);
    end
  endtask

  // One clock with the given inputs; outputs settle 1 ns after the edge.
  task automatic step(input logic en, input logic m, input logic tk, input logic sp, input logic sz);
    i_alarm_en  = en;
    i_match     = m;
    i_sec_tick  = tk;
    i_sw_stop   = sp;
    i_sw_snooze = sz;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    tbl[0]  = {5'b10000, 6'b00_0_00_0};  // armed, no match
    tbl[1]  = {5'b11000, 6'b01_1_00_0};  // match -> RING
    tbl[2]  = {5'b11010, 6'b11_0_00_1};  // stop -> HOLD with done
    tbl[3]  = {5'b11000, 6'b11_0_00_0};  // match held: stay HOLD
    tbl[4]  = {5'b11010, 6'b11_0_00_0};  // stop in HOLD ignored
    tbl[5]  = {5'b10000, 6'b00_0_00_0};  // match drops -> IDLE
    tbl[6]  = {5'b01000, 6'b00_0_00_0};  // disarmed match ignored
    tbl[7]  = {5'b11000, 6'b01_1_00_0};  // RING
    tbl[8]  = {5'b11100, 6'b01_1_00_0};  // one tick, still RING
    tbl[9]  = {5'b01010, 6'b00_0_00_0};  // disarm beats stop, no done
    tbl[10] = {5'b10010, 6'b00_0_00_0};  // stop in IDLE ignored
    tbl[11] = {5'b11000, 6'b01_1_00_0};  // RING again
    tbl[12] = {5'b10000, 6'b01_1_00_0};  // match drop does not stop ring
    tbl[13] = {5'b10010, 6'b11_0_00_1};  // stop -> HOLD
    tbl[14] = {5'b10000, 6'b00_0_00_0};  // match low -> IDLE
    tbl[15] = {5'b10001, 6'b00_0_00_0};  // snooze in IDLE ignored

    #2;
    check("reset_state", 6'b00_0_00_0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].en, tbl[i].match, tbl[i].tick, tbl[i].stop, tbl[i].snz);
      check($sformatf("vec%0d", i), {tbl[i].st, tbl[i].buzz, tbl[i].cnt, tbl[i].done});
    end

    // Ring timeout: ticks on alternate cycles, 59 keep ringing, 60th ends it.
    step(1, 1, 0, 0, 0);
    check("ring_start", 6'b01_1_00_0);
    for (int k = 0; k < 59; k++) begin
      step(1, 1, 1, 0, 0);
      step(1, 1, 0, 0, 0);
    end
    check("ring_59_ticks", 6'b01_1_00_0);
    step(1, 1, 1, 0, 0);
    check("ring_timeout", 6'b11_0_00_1);
    step(1, 1, 0, 0, 0);
    check("done_one_cycle", 6'b11_0_00_0);
    step(1, 0, 0, 0, 0);
    check("hold_release", 6'b00_0_00_0);

    // Asynchronous reset mid-RING.
    step(1, 1, 0, 0, 0);
    check("ring_before_rst", 6'b01_1_00_0);
    #3;
    rst = 1'b1;
    i_match = 1'b0;
    #1;
    check("async_rst", 6'b00_0_00_0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 0, 0, 0, 0);
    check("after_rst_idle", 6'b00_0_00_0);
    step(1, 1, 0, 0, 0);
    check("after_rst_ring", 6'b01_1_00_0);

`ifdef ALARM_SNOOZE_EN
    // First snooze, full snooze window, back to RING.
    step(1, 1, 0, 0, 1);
    check("snooze1", 6'b10_0_01_0);
    ticks(299);
    check("snooze_299", 6'b10_0_01_0);
    ticks(1);
    check("snooze_expire", 6'b01_1_01_0);
    step(1, 1, 0, 0, 1);
    check("snooze2", 6'b10_0_10_0);
    step(1, 1, 0, 0, 1);
    check("snooze_in_snooze", 6'b10_0_10_0);
    step(0, 1, 0, 0, 0);
    check("disarm_in_snooze", 6'b00_0_00_0);

    // Three snoozes, fourth acts as stop.
    step(1, 1, 0, 0, 0);
    check("ring_for_max", 6'b01_1_00_0);
    for (int s = 1; s <= 3; s++) begin
      step(1, 1, 0, 0, 1);
      check($sformatf("snz_max_%0d", s), {2'd2, 1'b0, 2'(s), 1'b0});
      ticks(300);
      check($sformatf("ring_max_%0d", s), {2'd1, 1'b1, 2'(s), 1'b0});
    end
    step(1, 1, 0, 0, 1);
    check("snooze_exhausted", 6'b11_0_11_1);
    step(1, 0, 0, 0, 0);
    check("cnt_clear_idle", 6'b00_0_00_0);

    // Stop and snooze together, and stop while snoozing.
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    check("snooze_a", 6'b10_0_01_0);
    ticks(300);
    step(1, 1, 0, 1, 1);
    check("stop_snooze_same", 6'b11_0_01_1);
    step(1, 1, 0, 0, 0);
    check("hold_stays", 6'b11_0_01_0);
    step(1, 0, 0, 0, 0);
    check("hold_to_idle", 6'b00_0_00_0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    step(1, 1, 0, 1, 0);
    check("stop_in_snooze", 6'b11_0_01_1);
    step(1, 0, 0, 0, 0);
    check("idle_end", 6'b00_0_00_0);
`else
    // Snooze path absent: snooze dismisses like stop.
    step(1, 1, 0, 0, 1);
    check("snooze_as_stop", 6'b11_0_00_1);
    step(1, 0, 0, 0, 0);
    check("idle_a", 6'b00_0_00_0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 1);
    check("stop_snooze_same", 6'b11_0_00_1);
    step(1, 1, 0, 0, 0);
    check("hold_stays", 6'b11_0_00_0);
    step(1, 0, 0, 0, 0);
    check("idle_end", 6'b00_0_00_0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_seq.md
ALARM_SEQ -- requirements
Module: alarm_seq

Interface
REQ-001 Parameter P_RING_SEC, default 60: seconds of continuous ringing before auto-stop.
REQ-002 Parameter P_SNOOZE_SEC, default 300: seconds of silence per snooze.
REQ-003 Parameter P_MAX_SNOOZE, default 3: snoozes allowed per alarm event; range 1..3.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 i_alarm_en  input  1  level; alarm armed when 1.
REQ-007 i_match  input  1  level; current time equals alarm time.
REQ-008 i_sec_tick  input  1  one-cycle pulse, once per second.
REQ-009 i_sw_stop  input  1  debounced one-cycle pulse; dismiss.
REQ-010 i_sw_snooze  input  1  debounced one-cycle pulse; snooze.
REQ-011 o_buzz_en  output  1  registered; drives buzzer enable, 1 only in RING.
REQ-012 o_state  output  2  registered; 0 IDLE, 1 RING, 2 SNOOZE, 3 HOLD.
REQ-013 o_snooze_cnt  output  2  registered; snoozes used in current event.
REQ-014 o_done  output  1  registered one-cycle pulse on any entry to HOLD.

Function
REQ-015 IDLE -> RING when i_alarm_en=1 and i_match=1; o_buzz_en high the cycle after i_match is first sampled high.
REQ-016 Internal 9-bit second counter sec_cnt increments on i_sec_tick in RING and SNOOZE; cleared on every state change.
REQ-017 RING -> HOLD when i_sw_stop=1, or when i_sec_tick=1 with sec_cnt = P_RING_SEC-1 (ring timeout).
REQ-018 RING -> SNOOZE when i_sw_snooze=1 and o_snooze_cnt < P_MAX_SNOOZE; o_snooze_cnt increments in the same edge.
REQ-019 RING with i_sw_snooze=1 and o_snooze_cnt = P_MAX_SNOOZE -> HOLD (snooze acts as stop).
REQ-020 SNOOZE -> RING when i_sec_tick=1 with sec_cnt = P_SNOOZE_SEC-1; SNOOZE -> HOLD on i_sw_stop=1; i_sw_snooze ignored in SNOOZE.
REQ-021 HOLD -> IDLE when i_match=0; prevents re-trigger within the matching second; o_snooze_cnt cleared on HOLD -> IDLE.
REQ-022 i_alarm_en=0 in any state -> IDLE next edge, o_snooze_cnt cleared, o_done not pulsed; highest priority after reset.
REQ-023 Priority within one cycle: i_alarm_en=0 > i_sw_stop > i_sw_snooze > timeout from i_sec_tick.
REQ-024 i_sw_stop/i_sw_snooze in IDLE or HOLD have no effect.
REQ-025 o_snooze_cnt saturates; never exceeds P_MAX_SNOOZE; no wrap.

Reset
REQ-026 rst=1 forces immediately, independent of clk: state IDLE, sec_cnt 0, o_buzz_en 0, o_state 0, o_snooze_cnt 0, o_done 0.
REQ-027 Reset asserted mid-RING or mid-SNOOZE silences the buzzer without o_done; after release the block re-enters RING only on a fresh IDLE evaluation of i_match.

Configuration
REQ-028 Macro ALARM_SNOOZE_EN defined: snooze path per REQ-018..REQ-020 present.
REQ-029 Macro ALARM_SNOOZE_EN undefined: SNOOZE state unreachable, i_sw_snooze behaves as i_sw_stop, o_snooze_cnt tied to 0.

Verification
REQ-030 i_alarm_en=1, i_match rises -> o_state=1 and o_buzz_en=1 one cycle later; 60 ticks with no buttons -> o_state=3, o_done pulse, o_buzz_en=0.
REQ-031 RING, i_sw_snooze pulse -> o_state=2, o_snooze_cnt=1; 300 ticks -> o_state=1, o_buzz_en=1.
REQ-032 Snooze 3 times, 4th i_sw_snooze in RING -> o_state=3, o_snooze_cnt=3; drop i_match -> o_state=0, o_snooze_cnt=0.
REQ-033 RING, i_sw_stop and i_sw_snooze same cycle -> o_state=3, o_snooze_cnt unchanged; i_match held 1 -> stays HOLD.
REQ-034 SNOOZE, i_alarm_en drops -> o_state=0 next edge, no o_done; rst pulse during RING -> o_buzz_en=0 asynchronously.
REQ-035 ALARM_SNOOZE_EN undefined: i_sw_snooze in RING -> o_state=3, o_snooze_cnt=0.
